rgb_pwm_fader: RTL and testbench

//   Downstream consumer of the blink/pattern stage: accepts 3-channel brightness targets over a

---
 rtl/rgb_pwm_fader.sv | 120 ++++++++++++
 tb/tb_rgb_pwm_fader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: accepts 3-channel brightness targets over valid/ready, ramps each
// channel one LSB per fade step toward its target and drives registered PWM LED pins.
// The applied duty is reloaded only at a PWM period boundary, so a period is never cut mid-way.
module rgb_pwm_fader #(
  parameter int PWM_W      = 8,
  parameter int STEP_DIV   = 1000,
  parameter int PRESC_W    = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3*PWM_W-1:0] cmd_rgb,
  output logic               busy,
  output logic               led_red,
  output logic               led_green,
  output logic               led_blue
);

  typedef enum logic {IDLE, FADE} state_t;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);
  localparam logic               PIN_OFF    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  state_t state, state_nxt;

  // Channel index 2 = red, 1 = green, 0 = blue, matching the cmd_rgb packing.
  logic [2:0][PWM_W-1:0] work, applied, target, step_work;
  logic [PWM_W-1:0]      pwm_cnt;
  logic [PRESC_W-1:0]    presc;
  logic                  accept, step, settle;

  assign accept = cmd_valid && cmd_ready;
  assign step   = (state == FADE) && (presc == PRESC_LAST);
  assign settle = step && (step_work == target);

  // Working duty after one fade step: each channel moves one LSB toward target, never past it.
  always_comb begin
    step_work = work;
    for (int unsigned i = 0; i < 3; i++) begin
      if (work[i] < target[i]) begin
        step_work[i] = work[i] + PWM_W'(1);
      end else if (work[i] > target[i]) begin
        step_work[i] = work[i] - PWM_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: start a fade only when the new target differs; leave on the settling step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && (cmd_rgb != work)) state_nxt = FADE;
      FADE: if (settle) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state == FADE);
  end

  // Fade datapath: target latch, step prescaler and working duties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
      presc  <= '0;
      work   <= '0;
    end else begin
      if (accept) begin
        target <= cmd_rgb;
        presc  <= '0;
      end else if (state == FADE) begin
        presc <= step ? '0 : presc + PRESC_W'(1);
      end
      if (step) begin
        work <= step_work;
      end
    end
  end

  // PWM counter and period-boundary reload of the applied duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      applied <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (pwm_cnt == '1) begin
        applied <= work;
      end
    end
  end

  // Registered LED pins: lit while the counter is below the applied duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_red   <= PIN_OFF;
      led_green <= PIN_OFF;
      led_blue  <= PIN_OFF;
    end else begin
      led_red   <= (pwm_cnt < applied[2]) ? ~PIN_OFF : PIN_OFF;
      led_green <= (pwm_cnt < applied[1]) ? ~PIN_OFF : PIN_OFF;
      led_blue  <= (pwm_cnt < applied[0]) ? ~PIN_OFF : PIN_OFF;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: directed and randomized commands checked every cycle against a
// closed-form reference model of the fader (PWM_W=4, STEP_DIV=2, active-low pins).
module tb_rgb_pwm_fader;

  localparam int W  = 4;
  localparam int SD = 2;
  localparam int PERIOD = 1 << W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [3*W-1:0] cmd_rgb = '0;
  logic           cmd_ready, busy, led_red, led_green, led_blue;

  rgb_pwm_fader #(
    .PWM_W(W),
    .STEP_DIV(SD),
    .PRESC_W(4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rgb(cmd_rgb),
    .busy(busy),
    .led_red(led_red),
    .led_green(led_green),
    .led_blue(led_blue)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model; index 0 = red, 1 = green, 2 = blue.
  int pcnt;
  int applied [3];
  int work [3];
  int start [3];
  int tgt [3];
  int exp_led [3];
  int el, dd;
  bit mbusy, accepted;

  int w, n, lr, lg, lb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int chan(input logic [3*W-1:0] v, input int i);
    logic [3*W-1:0] s;
    s = v >> (W * (2 - i));
    return int'(s[W-1:0]);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    pcnt = 0; el = 0; dd = 0; mbusy = 0; accepted = 0;
    for (int i = 0; i < 3; i++) begin
      applied[i] = 0; work[i] = 0; start[i] = 0; tgt[i] = 0; exp_led[i] = 1;
    end
  endtask

  // One clock edge of the model: duty k steps after accept = start moved min(dist, k) toward target.
  task automatic model_step();
    int d, m;
    for (int i = 0; i < 3; i++) exp_led[i] = (pcnt < applied[i]) ? 0 : 1;
    if (pcnt == PERIOD - 1) applied = work;
    pcnt = (pcnt + 1) % PERIOD;
    accepted = 0;
    if (mbusy) begin
      el++;
      for (int i = 0; i < 3; i++) begin
        d = tgt[i] - start[i];
        m = (iabs(d) < el / SD) ? iabs(d) : el / SD;
        work[i] = (d >= 0) ? start[i] + m : start[i] - m;
      end
      if (el == dd * SD) mbusy = 0;
    end else if (cmd_valid) begin
      accepted = 1;
      dd = 0;
      el = 0;
      for (int i = 0; i < 3; i++) begin
        start[i] = work[i];
        tgt[i] = chan(cmd_rgb, i);
        if (iabs(tgt[i] - start[i]) > dd) dd = iabs(tgt[i] - start[i]);
      end
      mbusy = (dd != 0);
    end
  endtask

  task automatic check_outputs();
    check("busy", busy, mbusy);
    check("cmd_ready", cmd_ready, !mbusy);
    check("led_red", led_red, exp_led[0]);
    check("led_green", led_green, exp_led[1]);
    check("led_blue", led_blue, exp_led[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_outputs();
  endtask

  task automatic pulse_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [3*W-1:0] v, output int waited);
    cmd_valid = 1'b1;
    cmd_rgb = v;
    waited = 0;
    accepted = 0;
    while (!accepted && waited < 1000) begin
      tick();
      waited++;
    end
    if (!accepted) check("accept_timeout", 0, 1);
    cmd_valid = 1'b0;
    cmd_rgb = 12'($urandom);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (mbusy && k < 1000) begin
      tick();
      k++;
    end
    if (mbusy) check("idle_timeout", 0, 1);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    repeat (20) tick();

    // Reset mid-run with no command: pins stay inactive.
    pulse_reset(3);
    repeat (20) tick();

    // Fade to {3,0,1}: busy for 3 steps * 2 clk.
    send(12'h301, w);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("busy_len", n, 6);
    wait_idle();
    repeat (40) tick();

    // Settled {8,0,15}: count lit cycles over one full period.
    send(12'h80F, w);
    wait_idle();
    repeat (2 * PERIOD) tick();
    lr = 0; lg = 0; lb = 0;
    repeat (PERIOD) begin
      tick();
      lr += (led_red == 1'b0) ? 1 : 0;
      lg += (led_green == 1'b0) ? 1 : 0;
      lb += (led_blue == 1'b0) ? 1 : 0;
    end
    check("red_lit_cnt", lr, 8);
    check("green_lit_cnt", lg, 0);
    check("blue_lit_cnt", lb, 15);

    // Back-to-back: full-scale fade, second command held until the first IDLE cycle.
    send(12'h000, w);
    wait_idle();
    send(12'hFFF, w);
    send(12'h000, w);
    check("b2b_wait", w, 31);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("fade_back_len", n, 30);
    wait_idle();
    repeat (20) tick();

    // Command equal to current duties: accepted without a fade.
    send(12'h000, w);
    check("equal_busy", busy, 0);
    check("equal_ready", cmd_ready, 1);
    repeat (5) tick();

    // Reset mid-fade abandons it.
    send(12'hFFF, w);
    repeat (10) tick();
    pulse_reset(2);
    repeat (40) tick();

    // Randomized traffic with random gaps, back-to-back holds and mid-fade resets.
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 4)) tick();
      send(12'($urandom), w);
      case ($urandom_range(0, 3))
        0: wait_idle();
        1: begin
          repeat ($urandom_range(1, 20)) tick();
          pulse_reset($urandom_range(1, 3));
        end
        2: ;
        default: repeat ($urandom_range(1, 40)) tick();
      endcase
    end
    wait_idle();
    repeat (3 * PERIOD) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
